alu_op_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 20-bit ALU operation datapath (NOT/AND/OR/XOR/INC/shift/rotate slots) for the core.
- Accepts one decoded instruction at a time via valid/ready, drives opcode and operands into the datapath, captures the result, and issues register-file writebacks.
- Owns the opcodes the datapath cannot complete alone:
  - SWAP: two writebacks.
  - JMP: redirect pulse.
  - TRAP: halt.
  - NOP: no write.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_op_classify.sv | 76 +++++++
 rtl/alu_op_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode map, width constants and sequencer state
//                encoding for the ALU operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 20;
    localparam int ALU_OP_W   = 5;
    localparam int ALU_REG_AW = 4;

    localparam logic [4:0] OP_TRAP  = 5'd0;
    localparam logic [4:0] OP_NOP   = 5'd1;
    localparam logic [4:0] OP_JMP   = 5'd2;
    localparam logic [4:0] OP_NOT   = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_OR    = 5'd10;
    localparam logic [4:0] OP_XOR   = 5'd11;
    localparam logic [4:0] OP_SHFTR = 5'd12;
    localparam logic [4:0] OP_SHFTL = 5'd13;
    localparam logic [4:0] OP_ROTR  = 5'd14;
    localparam logic [4:0] OP_ROTL  = 5'd15;
    localparam logic [4:0] OP_SWAP  = 5'd16;
    localparam logic [4:0] OP_INC   = 5'd17;

    localparam int         ST_W    = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_WB1  = 3'd2;
    localparam logic [2:0] ST_WB2  = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_classify.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_classify
//  Description : Combinational opcode decoder. Reports legality, whether a
//                writeback follows, SWAP/JMP/TRAP flavours, and whether
//                operand B must be forced to zero for the datapath.
//                Build option: ALU_SHIFT_OPS_EN makes opcodes 12-15 legal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_classify
    import alu_pkg::*;
#(
    parameter int OP_W = ALU_OP_W
) (
    input  logic [OP_W-1:0] i_op,
    output logic            o_is_legal,
    output logic            o_needs_wb,
    output logic            o_is_swap,
    output logic            o_is_jmp,
    output logic            o_is_trap,
    output logic            o_zero_b
);

    // Decode one opcode into its control flags; anything unlisted is illegal
    always_comb begin
        o_is_legal = 1'b0;
        o_needs_wb = 1'b0;
        o_is_swap  = 1'b0;
        o_is_jmp   = 1'b0;
        o_is_trap  = 1'b0;
        o_zero_b   = 1'b0;
        case (i_op)
            OP_TRAP: begin
                o_is_legal = 1'b1;
                o_is_trap  = 1'b1;
            end
            OP_NOP: begin
                o_is_legal = 1'b1;
            end
            OP_JMP: begin
                o_is_legal = 1'b1;
                o_is_jmp   = 1'b1;
            end
            OP_NOT: begin
                o_is_legal = 1'b1;
                o_needs_wb = 1'b1;
                o_zero_b   = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                o_is_legal = 1'b1;
                o_needs_wb = 1'b1;
            end
`ifdef ALU_SHIFT_OPS_EN
            OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL: begin
                o_is_legal = 1'b1;
                o_needs_wb = 1'b1;
            end
`endif
            OP_SWAP: begin
                o_is_legal = 1'b1;
                o_needs_wb = 1'b1;
                o_is_swap  = 1'b1;
            end
            OP_INC: begin
                o_is_legal = 1'b1;
                o_needs_wb = 1'b1;
                o_zero_b   = 1'b1;
            end
            default: begin
                o_is_legal = 1'b0;
            end
        endcase
    end

endmodule : alu_op_classify
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Unpipelined multi-cycle controller for the 20-bit ALU
//                datapath. Accepts one instruction, drives the datapath for
//                one EXEC cycle, then issues one (or two, for SWAP)
//                register-file writebacks. Handles JMP redirect, TRAP halt,
//                NOP and illegal-opcode reporting. All outputs registered.
//                Build option: ALU_SHIFT_OPS_EN enables opcodes 12-15.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_AW-1:0] issue_dst,
    input  logic [REG_AW-1:0] issue_dst2,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    output logic [OP_W-1:0]   dp_op,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    input  logic [DATA_W-1:0] dp_w,
    input  logic              dp_carry,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              jmp_valid,
    output logic [DATA_W-1:0] jmp_target,
    output logic              carry_flag,
    output logic              illegal_op,
    output logic              halted
);

    // Classification of the incoming opcode, latched at accept time
    logic w_is_legal;
    logic w_needs_wb;
    logic w_is_swap;
    logic w_is_jmp;
    logic w_is_trap;
    logic w_zero_b;
    logic w_is_inc;
    logic w_accept;

    logic [ST_W-1:0]   r_state;
    logic [REG_AW-1:0] r_dst;
    logic [REG_AW-1:0] r_dst2;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_needs_wb;
    logic              r_is_swap;
    logic              r_is_trap;
    logic              r_is_inc;

    logic              r_issue_ready;
    logic [OP_W-1:0]   r_dp_op;
    logic [DATA_W-1:0] r_dp_a;
    logic [DATA_W-1:0] r_dp_b;
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_jmp_valid;
    logic [DATA_W-1:0] r_jmp_target;
    logic              r_carry;
    logic              r_illegal;
    logic              r_halted;

    alu_op_classify #(
        .OP_W (OP_W)
    ) u_classify (
        .i_op       (issue_op),
        .o_is_legal (w_is_legal),
        .o_needs_wb (w_needs_wb),
        .o_is_swap  (w_is_swap),
        .o_is_jmp   (w_is_jmp),
        .o_is_trap  (w_is_trap),
        .o_zero_b   (w_zero_b)
    );

    assign w_is_inc = (issue_op == OP_INC);
    assign w_accept = issue_valid && r_issue_ready;

    // Sequencer FSM; every output is computed one cycle ahead and registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_dst         <= '0;
            r_dst2        <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_needs_wb    <= 1'b0;
            r_is_swap     <= 1'b0;
            r_is_trap     <= 1'b0;
            r_is_inc      <= 1'b0;
            r_issue_ready <= 1'b0;
            r_dp_op       <= '0;
            r_dp_a        <= '0;
            r_dp_b        <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
            r_jmp_valid   <= 1'b0;
            r_jmp_target  <= '0;
            r_carry       <= 1'b0;
            r_illegal     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            // Pulses last exactly the EXEC cycle
            r_jmp_valid <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state       <= ST_EXEC;
                        r_issue_ready <= 1'b0;
                        r_dst         <= issue_dst;
                        r_dst2        <= issue_dst2;
                        r_a           <= issue_a;
                        r_b           <= issue_b;
                        r_needs_wb    <= w_needs_wb;
                        r_is_swap     <= w_is_swap;
                        r_is_trap     <= w_is_trap;
                        r_is_inc      <= w_is_inc;
                        // Datapath sees the operands during EXEC only
                        r_dp_op       <= issue_op;
                        r_dp_a        <= issue_a;
                        r_dp_b        <= w_zero_b ? '0 : issue_b;
                        r_jmp_valid   <= w_is_jmp;
                        r_jmp_target  <= w_is_jmp ? issue_a : '0;
                        r_illegal     <= ~w_is_legal;
                    end else begin
                        r_issue_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_dp_op      <= '0;
                    r_dp_a       <= '0;
                    r_dp_b       <= '0;
                    r_jmp_target <= '0;
                    if (r_is_inc) begin
                        r_carry <= dp_carry;
                    end
                    if (r_needs_wb) begin
                        r_state    <= ST_WB1;
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= r_dst;
                        r_wb_data  <= r_is_swap ? r_b : dp_w;
                    end else if (r_is_trap) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_issue_ready <= 1'b1;
                    end
                end
                ST_WB1: begin
                    if (wb_ready) begin
                        if (r_is_swap) begin
                            // Second half of SWAP: old A goes to dst2
                            r_state   <= ST_WB2;
                            r_wb_addr <= r_dst2;
                            r_wb_data <= r_a;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_wb_valid    <= 1'b0;
                            r_wb_addr     <= '0;
                            r_wb_data     <= '0;
                            r_issue_ready <= 1'b1;
                        end
                    end
                end
                ST_WB2: begin
                    if (wb_ready) begin
                        r_state       <= ST_IDLE;
                        r_wb_valid    <= 1'b0;
                        r_wb_addr     <= '0;
                        r_wb_data     <= '0;
                        r_issue_ready <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_halted      <= 1'b1;
                    r_issue_ready <= 1'b0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_issue_ready <= 1'b0;
                end
            endcase
        end
    end

    assign issue_ready = r_issue_ready;
    assign dp_op       = r_dp_op;
    assign dp_a        = r_dp_a;
    assign dp_b        = r_dp_b;
    assign wb_valid    = r_wb_valid;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;
    assign jmp_valid   = r_jmp_valid;
    assign jmp_target  = r_jmp_target;
    assign carry_flag  = r_carry;
    assign illegal_op  = r_illegal;
    assign halted      = r_halted;

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer. Provides a
//                behavioural datapath, directed and random instructions, and
//                a reference model of expected writebacks, pulses, latency
//                and carry. Honours ALU_SHIFT_OPS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

`ifdef ALU_SHIFT_OPS_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_op;
    logic [3:0]  issue_dst;
    logic [3:0]  issue_dst2;
    logic [19:0] issue_a;
    logic [19:0] issue_b;
    logic [4:0]  dp_op;
    logic [19:0] dp_a;
    logic [19:0] dp_b;
    logic [19:0] dp_w;
    logic        dp_carry;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_addr;
    logic [19:0] wb_data;
    logic        jmp_valid;
    logic [19:0] jmp_target;
    logic        carry_flag;
    logic        illegal_op;
    logic        halted;

    int errors = 0;
    int checks = 0;
    bit model_carry = 1'b0;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_dst   (issue_dst),
        .issue_dst2  (issue_dst2),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .dp_op       (dp_op),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .dp_w        (dp_w),
        .dp_carry    (dp_carry),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .carry_flag  (carry_flag),
        .illegal_op  (illegal_op),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Behavioural ALU datapath; shifts/rotates move by one bit
    always_comb begin
        logic [20:0] sum;
        sum      = {1'b0, dp_a} + {1'b0, dp_b} + 21'd1;
        dp_w     = '0;
        dp_carry = 1'b0;
        case (dp_op)
            5'd8:  dp_w = ~dp_a;
            5'd9:  dp_w = dp_a & dp_b;
            5'd10: dp_w = dp_a | dp_b;
            5'd11: dp_w = dp_a ^ dp_b;
            5'd12: dp_w = dp_a >> 1;
            5'd13: dp_w = dp_a << 1;
            5'd14: dp_w = {dp_a[0], dp_a[19:1]};
            5'd15: dp_w = {dp_a[18:0], dp_a[19]};
            5'd17: {dp_carry, dp_w} = sum;
            default: dp_w = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected ALU result from arithmetic definitions of each opcode
    function automatic logic [19:0] ref_result(input int op, input int unsigned a, input int unsigned b);
        int unsigned r;
        case (op)
            8:  r = 32'hFFFFF - a;
            9:  r = a & b;
            10: r = a | b;
            11: r = a ^ b;
            12: r = a / 2;
            13: r = (a * 2) % 32'h100000;
            14: r = (a / 2) + (a % 2) * 32'h80000;
            15: r = (a * 2) % 32'h100000 + a / 32'h80000;
            17: r = (a + 1) % 32'h100000;
            default: r = 0;
        endcase
        return r[19:0];
    endfunction

    function automatic bit ref_legal(input int op);
        if (op == 0 || op == 1 || op == 2) return 1'b1;
        if (op >= 8 && op <= 11) return 1'b1;
        if (op >= 12 && op <= 15) return SHIFT_EN;
        if (op == 16 || op == 17) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one instruction and check everything it should (and should not) do
    task automatic run_instr(input logic [4:0] op, input logic [3:0] dst, input logic [3:0] dst2,
                             input logic [19:0] a, input logic [19:0] b, input int stall);
        bit legal, writes, swap, jmp, trap;
        int exp_end, end_cyc, first_wb, waits;
        logic [23:0] exp_q[$];
        logic [23:0] got_q[$];
        logic [23:0] snap;
        bit have_snap, unstable, extra_pulse, dp_leak;
        int opi;
        opi    = int'(op);
        legal  = ref_legal(opi);
        swap   = (opi == 16);
        jmp    = (opi == 2);
        trap   = (opi == 0);
        writes = legal && opi >= 8;
        if (swap) begin
            exp_q.push_back({dst, b});
            exp_q.push_back({dst2, a});
            exp_end = 4 + stall;
        end else if (writes) begin
            exp_q.push_back({dst, ref_result(opi, a, b)});
            exp_end = 3 + stall;
        end else begin
            exp_end = 2;
        end
        if (opi == 17) model_carry = (a == 20'hFFFFF);

        chk("ready_before_issue", issue_ready, 1);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_dst   = dst;
        issue_dst2  = dst2;
        issue_a     = a;
        issue_b     = b;
        @(negedge clk);
        issue_valid = 1'b0;
        issue_op    = $urandom_range(0, 31);
        issue_a     = $urandom;
        // EXEC cycle
        chk("exec_ready_low", issue_ready, 0);
        chk("exec_dp_op", dp_op, op);
        chk("exec_dp_a", dp_a, a);
        chk("exec_dp_b", dp_b, (opi == 8 || opi == 17) ? 20'd0 : b);
        chk("exec_jmp_valid", jmp_valid, jmp);
        if (jmp) chk("exec_jmp_target", jmp_target, a);
        chk("exec_illegal", illegal_op, !legal);
        chk("exec_no_wb", wb_valid, 0);

        end_cyc = -1; first_wb = -1; waits = stall;
        have_snap = 0; unstable = 0; extra_pulse = 0; dp_leak = 0;
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            if (issue_ready || halted) begin
                end_cyc = c;
                break;
            end
            if (jmp_valid || illegal_op) extra_pulse = 1;
            if (dp_op != 0 || dp_a != 0 || dp_b != 0) dp_leak = 1;
            if (wb_valid) begin
                if (first_wb < 0) first_wb = c;
                if (!have_snap) begin
                    snap = {wb_addr, wb_data};
                    have_snap = 1;
                end else if ({wb_addr, wb_data} !== snap) begin
                    unstable = 1;
                end
                if (waits > 0) begin
                    wb_ready = 1'b0;
                    waits--;
                end else begin
                    wb_ready = 1'b1;
                    got_q.push_back({wb_addr, wb_data});
                    have_snap = 0;
                end
            end else begin
                wb_ready = 1'b1;
            end
        end
        chk("done_cycle", end_cyc, exp_end);
        chk("halted_state", halted, trap);
        chk("wb_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("wb_addr_data", got_q[i], exp_q[i]);
        if (writes) chk("first_wb_cycle", first_wb, 2);
        chk("wb_stable_while_stalled", unstable, 0);
        chk("pulse_single_cycle", extra_pulse, 0);
        chk("dp_zero_outside_exec", dp_leak, 0);
        chk("wb_idle_after", wb_valid, 0);
        chk("carry_flag", carry_flag, model_carry);
    endtask

    initial begin
        bit seen_ready, seen_wb;
        rst = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_dst = '0; issue_dst2 = '0;
        issue_a = '0; issue_b = '0; wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", issue_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_dp_op", dp_op, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", issue_ready, 1);

        // Directed plan items
        run_instr(5'd9, 4'd3, 4'd0, 20'hF0F0F, 20'h0FFFF, 0);
        run_instr(5'd17, 4'd4, 4'd0, 20'hFFFFF, 20'h12345, 0);
        run_instr(5'd17, 4'd5, 4'd0, 20'h00001, 20'h00000, 0);
        run_instr(5'd16, 4'd1, 4'd2, 20'h12345, 20'hABCDE, 3);
        run_instr(5'd16, 4'd7, 4'd7, 20'h0AAAA, 20'h05555, 1);
        run_instr(5'd2, 4'd0, 4'd0, 20'h00400, 20'h00000, 0);
        run_instr(5'd1, 4'd6, 4'd0, 20'h11111, 20'h22222, 0);
        run_instr(5'd5, 4'd6, 4'd0, 20'h11111, 20'h22222, 0);
        run_instr(5'd13, 4'd8, 4'd0, 20'h80001, 20'h00000, 0);
        run_instr(5'd8, 4'd9, 4'd0, 20'h0F0F0, 20'hFFFFF, 2);

        // Random instructions (TRAP excluded, it ends the run)
        for (int n = 0; n < 40; n++) begin
            run_instr(5'($urandom_range(1, 31)), 4'($urandom), 4'($urandom),
                      20'($urandom), 20'($urandom), $urandom_range(0, 3));
        end

        // TRAP then ignore further requests
        run_instr(5'd0, 4'd0, 4'd0, 20'h0, 20'h0, 0);
        seen_ready = 0; seen_wb = 0;
        issue_valid = 1'b1;
        issue_op = 5'd9;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (issue_ready) seen_ready = 1;
            if (wb_valid) seen_wb = 1;
        end
        issue_valid = 1'b0;
        chk("halt_ready_stays_low", seen_ready, 0);
        chk("halt_no_wb", seen_wb, 0);
        chk("halt_sticky", halted, 1);

        rst = 1'b1;
        @(negedge clk);
        chk("halt_cleared_by_rst", halted, 0);
        rst = 1'b0;
        model_carry = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of WB1
        chk("ready_before_abort", issue_ready, 1);
        issue_valid = 1'b1; issue_op = 5'd10; issue_dst = 4'd2;
        issue_a = 20'h00F00; issue_b = 20'h0000F; wb_ready = 1'b0;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_wb1", wb_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_wb_cleared", wb_valid, 0);
        chk("abort_wb_data_cleared", wb_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_back_idle", issue_ready, 1);
        chk("abort_no_wb", wb_valid, 0);
        run_instr(5'd11, 4'd12, 4'd0, 20'h5A5A5, 20'hFFFFF, 0);
        run_instr(5'd17, 4'd13, 4'd0, 20'h7FFFF, 20'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire
